// File: rtl/calc_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// calc_arbiter_pkg
// Shared definitions for the calc arbiter slice:
//   - arb_state_t : sequencer state encoding (3 bits)
//   - OP_*        : calc op codes
//   - CALC_DW / CALC_OPW : calc operand/result and op widths
// -----------------------------------------------------------------------------
package calc_arbiter_pkg;

   localparam int CALC_DW  = 8;
   localparam int CALC_OPW = 2;

   localparam logic [CALC_OPW-1:0] OP_ZERO = 2'b00;
   localparam logic [CALC_OPW-1:0] OP_ADD  = 2'b01;
   localparam logic [CALC_OPW-1:0] OP_SHR  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_LO = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_RESP    = 3'd4
   } arb_state_t;

endpackage

// File: rtl/calc_arbiter_if.sv
// -----------------------------------------------------------------------------
// calc_arbiter_if
// Bundles the requester side and the calc side of the arbiter.
//   Requester side : req, req_in, req_op (to arbiter); gnt, rsp_valid,
//                    rsp_data, rsp_ovf, rsp_err (from arbiter)
//   Calc side      : calc_s, calc_in, calc_op (from arbiter); calc_done,
//                    calc_out, calc_ovf (to arbiter)
// Modports:
//   master : the arbiter's view
//   slave  : the environment's view (clients plus calc)
// -----------------------------------------------------------------------------
interface calc_arbiter_if #(
   parameter int NREQ = 4
);
   import calc_arbiter_pkg::*;

   logic [NREQ-1:0]          req;
   logic [CALC_DW*NREQ-1:0]  req_in;
   logic [CALC_OPW*NREQ-1:0] req_op;
   logic [NREQ-1:0]          gnt;
   logic [NREQ-1:0]          rsp_valid;
   logic [CALC_DW-1:0]       rsp_data;
   logic                     rsp_ovf;
   logic                     rsp_err;

   logic                     calc_s;
   logic [CALC_DW-1:0]       calc_in;
   logic [CALC_OPW-1:0]      calc_op;
   logic                     calc_done;
   logic [CALC_DW-1:0]       calc_out;
   logic                     calc_ovf;

   modport master (
      input  req, req_in, req_op, calc_done, calc_out, calc_ovf,
      output gnt, rsp_valid, rsp_data, rsp_ovf, rsp_err, calc_s, calc_in, calc_op
   );

   modport slave (
      output req, req_in, req_op, calc_done, calc_out, calc_ovf,
      input  gnt, rsp_valid, rsp_data, rsp_ovf, rsp_err, calc_s, calc_in, calc_op
   );

endinterface

// File: rtl/calc_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts at index ptr
// and wraps from NREQ-1 back to 0; the first set request bit wins.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  PW    index with highest priority (must be < NREQ)
//   grant out NREQ  one-hot winner (all zero when no request)
//   idx   out PW    winner index (0 when no request)
//   any   out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   idx,
   output logic            any
);

   // cand_idx[k] is the requester examined at priority rank k: (ptr + k) mod NREQ.
   // ptr + k < 2*NREQ, so one conditional subtraction is enough.
   logic [PW-1:0] cand_idx [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
         logic [PW:0] sum;
         assign sum = {1'b0, ptr} + (PW+1)'(gi);
         assign cand_idx[gi] = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                                      : sum[PW-1:0];
      end
   endgenerate

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any && req[cand_idx[k]]) begin
            any = 1'b1;
            idx = cand_idx[k];
         end
      end
      if (any) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/calc_arbiter.sv
// -----------------------------------------------------------------------------
// calc_arbiter
// Round-robin arbiter/sequencer sharing one calc datapath between NREQ
// requesters. Grants one requester, issues its operand/op with a start pulse,
// follows calc's done handshake (low = accepted, high = finished), captures
// the result and returns it with a one-cycle rsp_valid pulse. Each wait state
// is bounded by TMO cycles; an expired wait returns rsp_err=1 with zero data
// and leaves the round-robin pointer where it was.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    calc_arbiter_if.master (requester and calc handshakes)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module calc_arbiter
   import calc_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TMO  = 15
) (
   input  logic           clk,
   input  logic           reset,
   calc_arbiter_if.master bus
);

   localparam int              PW       = $clog2(NREQ);
   localparam int              TW       = $clog2(TMO + 1);
   localparam logic [TW-1:0]   TMO_V    = TW'(TMO);
   localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

   arb_state_t          state_reg;
   logic [PW-1:0]       ptr_reg;
   logic [PW-1:0]       win_reg;
   logic [TW-1:0]       timer_reg;
   logic [NREQ-1:0]     gnt_reg;
   logic [NREQ-1:0]     rsp_valid_reg;
   logic [CALC_DW-1:0]  rsp_data_reg;
   logic                rsp_ovf_reg;
   logic                rsp_err_reg;
   logic                calc_s_reg;
   logic [CALC_DW-1:0]  calc_in_reg;
   logic [CALC_OPW-1:0] calc_op_reg;

   logic [NREQ-1:0]     pick_grant;
   logic [PW-1:0]       pick_idx;
   logic                pick_any;
   logic [CALC_DW-1:0]  sel_in;
   logic [CALC_OPW-1:0] sel_op;
   logic [PW-1:0]       ptr_next;
   logic [TW-1:0]       timer_next;
   logic                timeout;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req   (bus.req),
      .ptr   (ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign sel_in = bus.req_in[CALC_DW*int'(pick_idx) +: CALC_DW];
   assign sel_op = bus.req_op[CALC_OPW*int'(pick_idx) +: CALC_OPW];

   assign ptr_next = (win_reg == LAST_IDX) ? '0 : win_reg + 1'b1;

   // Saturating count; timeout fires on the cycle the count would reach TMO,
   // so each wait state lasts at most TMO cycles.
   assign timer_next = (timer_reg == '1) ? timer_reg : timer_reg + 1'b1;
   assign timeout    = (timer_next == TMO_V);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         ptr_reg       <= '0;
         win_reg       <= '0;
         timer_reg     <= '0;
         gnt_reg       <= '0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
         rsp_ovf_reg   <= 1'b0;
         rsp_err_reg   <= 1'b0;
         calc_s_reg    <= 1'b0;
         calc_in_reg   <= '0;
         calc_op_reg   <= '0;
      end else begin
         rsp_valid_reg <= '0;
         calc_s_reg    <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (pick_any) begin
                  win_reg     <= pick_idx;
                  gnt_reg     <= pick_grant;
                  calc_in_reg <= sel_in;
                  calc_op_reg <= sel_op;
                  // Registered here so the start pulse coincides with ISSUE.
                  calc_s_reg  <= 1'b1;
                  state_reg   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               timer_reg <= '0;
               state_reg <= ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
               if (!bus.calc_done) begin
                  timer_reg <= '0;
                  state_reg <= ST_WAIT_HI;
               end else if (timeout) begin
                  rsp_valid_reg <= gnt_reg;
                  rsp_err_reg   <= 1'b1;
                  rsp_data_reg  <= '0;
                  rsp_ovf_reg   <= 1'b0;
                  state_reg     <= ST_RESP;
               end else begin
                  timer_reg <= timer_next;
               end
            end
            ST_WAIT_HI: begin
               if (bus.calc_done) begin
                  rsp_valid_reg <= gnt_reg;
                  rsp_err_reg   <= 1'b0;
                  rsp_data_reg  <= bus.calc_out;
                  rsp_ovf_reg   <= bus.calc_ovf;
                  state_reg     <= ST_RESP;
               end else if (timeout) begin
                  rsp_valid_reg <= gnt_reg;
                  rsp_err_reg   <= 1'b1;
                  rsp_data_reg  <= '0;
                  rsp_ovf_reg   <= 1'b0;
                  state_reg     <= ST_RESP;
               end else begin
                  timer_reg <= timer_next;
               end
            end
            ST_RESP: begin
               gnt_reg <= '0;
               // A failed transaction keeps the same requester at top priority.
               if (!rsp_err_reg) begin
                  ptr_reg <= ptr_next;
               end
               state_reg <= ST_IDLE;
            end
            default: begin
               gnt_reg   <= '0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_reg;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_ovf   = rsp_ovf_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.calc_s    = calc_s_reg;
   assign bus.calc_in   = calc_in_reg;
   assign bus.calc_op   = calc_op_reg;

endmodule

// File: tb/tb_calc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_calc_arbiter
// Directed bench for calc_arbiter (NREQ=4, TMO=15) with a small calc model:
//   mode 0 : done drops 1 cycle after s, rises 2 cycles later with the result
//            (ZERO -> 0, ADD -> in+in with carry as ovf, SHR -> in>>1)
//   mode 1 : done stuck high
//   mode 2 : done drops after s and never rises
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_calc_arbiter;
   import calc_arbiter_pkg::*;

   localparam int NREQ = 4;
   localparam int TMO  = 15;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   calc_arbiter_if #(.NREQ(NREQ)) bus ();

   calc_arbiter #(
      .NREQ (NREQ),
      .TMO  (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- calc model ----------------
   int         calc_mode = 0;
   logic [1:0] busy_cnt  = 2'd0;
   logic       m_done    = 1'b1;
   logic [7:0] m_out     = 8'h00;
   logic       m_ovf     = 1'b0;
   logic [7:0] m_in      = 8'h00;
   logic [1:0] m_op      = 2'b00;

   function automatic logic [8:0] model_result(input logic [7:0] a, input logic [1:0] op);
      case (op)
         OP_ZERO: return 9'd0;
         OP_ADD:  return {1'b0, a} + {1'b0, a};
         OP_SHR:  return {1'b0, a >> 1};
         default: return 9'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (calc_mode == 1) begin
         m_done <= 1'b1;
      end else if (calc_mode == 2) begin
         if (bus.calc_s) m_done <= 1'b0;
      end else begin
         if (bus.calc_s) begin
            m_done   <= 1'b0;
            busy_cnt <= 2'd2;
            m_in     <= bus.calc_in;
            m_op     <= bus.calc_op;
         end else if (busy_cnt == 2'd1) begin
            busy_cnt       <= 2'd0;
            m_done         <= 1'b1;
            {m_ovf, m_out} <= model_result(m_in, m_op);
         end else if (busy_cnt != 2'd0) begin
            busy_cnt <= busy_cnt - 2'd1;
         end else begin
            m_done <= 1'b1;
         end
      end
   end

   assign bus.calc_done = m_done;
   assign bus.calc_out  = m_out;
   assign bus.calc_ovf  = m_ovf;

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Ticks until rsp_valid is seen; lat = ticks taken, -1 if the bound expires.
   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         if (bus.rsp_valid != '0) begin
            lat = i;
            break;
         end
      end
      $display("txn: rsp_valid=%b data=%h ovf=%b err=%b lat=%0d",
               bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_err, lat);
   endtask

   task automatic wait_gnt(output int lat);
      lat = -1;
      for (int i = 0; i <= 40; i++) begin
         if (bus.gnt != '0) begin
            lat = i;
            break;
         end
         tick(1);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset       = 1'b1;
      bus.req     = '0;
      bus.req_in  = '0;
      bus.req_op  = '0;
      tick(2);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.rsp_valid !== 4'b0000 || bus.calc_s !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: gnt=%b rsp_valid=%b calc_s=%b want 0000 0000 0", bus.gnt, bus.rsp_valid, bus.calc_s);
      end
      checks++;
      if ({bus.rsp_data, bus.rsp_ovf, bus.rsp_err} !== 10'd0 || {bus.calc_in, bus.calc_op} !== 10'd0) begin
         errors++;
         $display("FAIL reset_data: rsp_data=%h ovf=%b err=%b calc_in=%h calc_op=%b want all zero",
                  bus.rsp_data, bus.rsp_ovf, bus.rsp_err, bus.calc_in, bus.calc_op);
      end
      reset = 1'b0;
      tick(2);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.calc_s !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: gnt=%b calc_s=%b want 0000 0", bus.gnt, bus.calc_s);
      end
   endtask

   task automatic test_single();
      int lat;
      bus.req_in[7:0] = 8'h05;
      bus.req_op[1:0] = OP_ADD;
      bus.req         = 4'b0001;
      tick(1);
      checks++;
      if (bus.gnt !== 4'b0001 || bus.calc_s !== 1'b1 || bus.calc_in !== 8'h05 || bus.calc_op !== 2'b01) begin
         errors++;
         $display("FAIL single_issue: gnt=%b calc_s=%b calc_in=%h calc_op=%b want 0001 1 05 01",
                  bus.gnt, bus.calc_s, bus.calc_in, bus.calc_op);
      end
      tick(1);
      checks++;
      if (bus.calc_s !== 1'b0 || bus.calc_in !== 8'h05 || bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL single_s_pulse: calc_s=%b calc_in=%h gnt=%b want 0 05 0001", bus.calc_s, bus.calc_in, bus.gnt);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 3 || bus.rsp_valid !== 4'b0001) begin
         errors++;
         $display("FAIL single_rsp_timing: lat=%0d rsp_valid=%b want 3 0001", lat, bus.rsp_valid);
      end
      checks++;
      if (bus.rsp_data !== 8'h0A || bus.rsp_ovf !== 1'b0 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp_data: data=%h ovf=%b err=%b want 0a 0 0", bus.rsp_data, bus.rsp_ovf, bus.rsp_err);
      end
      bus.req = '0;
      tick(1);
      checks++;
      if (bus.rsp_valid !== 4'b0000 || bus.gnt !== 4'b0000 || bus.rsp_data !== 8'h0A) begin
         errors++;
         $display("FAIL single_after: rsp_valid=%b gnt=%b data=%h want 0000 0000 0a", bus.rsp_valid, bus.gnt, bus.rsp_data);
      end
   endtask

   task automatic test_fairness();
      int         lat;
      logic [3:0] expv;
      logic [7:0] exp_data;
      reset = 1'b1;
      tick(1);
      reset      = 1'b0;
      bus.req_in = {8'h04, 8'h03, 8'h02, 8'h01};
      bus.req_op = {OP_ADD, OP_ADD, OP_ADD, OP_ADD};
      bus.req    = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         expv     = 4'b0001 << (n % NREQ);
         exp_data = 8'(((n % NREQ) + 1) * 2);
         wait_gnt(lat);
         checks++;
         if (bus.gnt !== expv) begin
            errors++;
            $display("FAIL fair_gnt%0d: gnt=%b want %b", n, bus.gnt, expv);
         end
         wait_rsp(lat);
         checks++;
         if (bus.rsp_valid !== expv || bus.rsp_data !== exp_data || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL fair_rsp%0d: rsp_valid=%b data=%h err=%b want %b %h 0",
                     n, bus.rsp_valid, bus.rsp_data, bus.rsp_err, expv, exp_data);
         end
         if (n == 4) bus.req = '0;
         else        bus.req[n % NREQ] = 1'b0;
         tick(1);
         checks++;
         if (bus.gnt !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL fair_idle_gap%0d: gnt=%b rsp_valid=%b want 0000 0000", n, bus.gnt, bus.rsp_valid);
         end
         tick(1);
         if (n < 4) bus.req[n % NREQ] = 1'b1;
      end
   endtask

   task automatic test_wrap_skip();
      int lat;
      // pointer is 1 here; serving requester 2 moves it to 3
      bus.req_in[23:16] = 8'h90;
      bus.req_op[5:4]   = OP_ADD;
      bus.req           = 4'b0100;
      tick(1);
      checks++;
      if (bus.gnt !== 4'b0100) begin
         errors++;
         $display("FAIL wrap_first_gnt: gnt=%b want 0100", bus.gnt);
      end
      wait_rsp(lat);
      checks++;
      if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 8'h20 || bus.rsp_ovf !== 1'b1) begin
         errors++;
         $display("FAIL wrap_ovf_rsp: rsp_valid=%b data=%h ovf=%b want 0100 20 1", bus.rsp_valid, bus.rsp_data, bus.rsp_ovf);
      end
      bus.req = '0;
      tick(1);
      bus.req_in[7:0]   = 8'h81;
      bus.req_op[1:0]   = OP_SHR;
      bus.req_in[23:16] = 8'h22;
      bus.req_op[5:4]   = OP_SHR;
      bus.req           = 4'b0101;
      tick(1);
      checks++;
      if (bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_gnt0: gnt=%b want 0001", bus.gnt);
      end
      wait_rsp(lat);
      checks++;
      if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 8'h40 || bus.rsp_ovf !== 1'b0) begin
         errors++;
         $display("FAIL wrap_rsp0: rsp_valid=%b data=%h ovf=%b want 0001 40 0", bus.rsp_valid, bus.rsp_data, bus.rsp_ovf);
      end
      bus.req = 4'b0100;
      tick(2);
      checks++;
      if (bus.gnt !== 4'b0100) begin
         errors++;
         $display("FAIL wrap_gnt2: gnt=%b want 0100", bus.gnt);
      end
      wait_rsp(lat);
      checks++;
      if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 8'h11 || lat !== 4) begin
         errors++;
         $display("FAIL wrap_rsp2: rsp_valid=%b data=%h lat=%0d want 0100 11 4", bus.rsp_valid, bus.rsp_data, lat);
      end
      bus.req = '0;
      tick(1);
   endtask

   task automatic test_timeout_lo();
      int lat;
      calc_mode         = 1;
      bus.req_in[15:8]  = 8'h11;
      bus.req_op[3:2]   = OP_ADD;
      bus.req           = 4'b0010;
      tick(1);
      checks++;
      if (bus.gnt !== 4'b0010 || bus.calc_s !== 1'b1) begin
         errors++;
         $display("FAIL tmo_lo_issue: gnt=%b calc_s=%b want 0010 1", bus.gnt, bus.calc_s);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 16 || bus.rsp_valid !== 4'b0010) begin
         errors++;
         $display("FAIL tmo_lo_timing: lat=%0d rsp_valid=%b want 16 0010", lat, bus.rsp_valid);
      end
      checks++;
      if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h00 || bus.rsp_ovf !== 1'b0) begin
         errors++;
         $display("FAIL tmo_lo_rsp: err=%b data=%h ovf=%b want 1 00 0", bus.rsp_err, bus.rsp_data, bus.rsp_ovf);
      end
      bus.req = '0;
      tick(1);
   endtask

   task automatic test_timeout_hi();
      int lat;
      calc_mode         = 2;
      bus.req_in[7:0]   = 8'h09;
      bus.req_op[1:0]   = OP_ADD;
      bus.req_in[23:16] = 8'h33;
      bus.req_op[5:4]   = OP_ADD;
      bus.req           = 4'b0101;
      tick(1);
      // Pointer must still be 3 after the error: requester 0 wins, not 2.
      checks++;
      if (bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL tmo_ptr_hold: gnt=%b want 0001", bus.gnt);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 17 || bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h00) begin
         errors++;
         $display("FAIL tmo_hi_rsp: lat=%0d rsp_valid=%b err=%b data=%h want 17 0001 1 00",
                  lat, bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      calc_mode = 0;
      bus.req   = 4'b0100;
      tick(2);
      checks++;
      if (bus.gnt !== 4'b0100) begin
         errors++;
         $display("FAIL tmo_hi_next_gnt: gnt=%b want 0100", bus.gnt);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 4 || bus.rsp_valid !== 4'b0100 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 8'h66) begin
         errors++;
         $display("FAIL tmo_hi_next_rsp: lat=%0d rsp_valid=%b err=%b data=%h want 4 0100 0 66",
                  lat, bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      bus.req = '0;
      tick(1);
   endtask

   task automatic test_async_reset();
      int lat;
      calc_mode         = 2;
      bus.req_in[23:16] = 8'h44;
      bus.req           = 4'b0100;
      tick(1);
      checks++;
      if (bus.gnt !== 4'b0100) begin
         errors++;
         $display("FAIL arst_setup_gnt: gnt=%b want 0100", bus.gnt);
      end
      tick(2);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.gnt !== 4'b0000 || bus.calc_s !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.calc_in !== 8'h00) begin
         errors++;
         $display("FAIL arst_immediate: gnt=%b calc_s=%b rsp_valid=%b calc_in=%h want 0000 0 0000 00",
                  bus.gnt, bus.calc_s, bus.rsp_valid, bus.calc_in);
      end
      calc_mode         = 0;
      bus.req_in[15:8]  = 8'h07;
      bus.req_op[3:2]   = OP_ADD;
      bus.req_in[31:24] = 8'h55;
      bus.req_op[7:6]   = OP_ADD;
      bus.req           = 4'b1010;
      tick(1);
      checks++;
      if (bus.rsp_valid !== 4'b0000 || bus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL arst_held: rsp_valid=%b gnt=%b want 0000 0000", bus.rsp_valid, bus.gnt);
      end
      reset = 1'b0;
      tick(1);
      // Pointer back at 0: requester 1 wins over 3.
      checks++;
      if (bus.gnt !== 4'b0010 || bus.calc_s !== 1'b1 || bus.calc_in !== 8'h07) begin
         errors++;
         $display("FAIL arst_regrant: gnt=%b calc_s=%b calc_in=%h want 0010 1 07", bus.gnt, bus.calc_s, bus.calc_in);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 4 || bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 8'h0E || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL arst_rsp: lat=%0d rsp_valid=%b data=%h err=%b want 4 0010 0e 0",
                  lat, bus.rsp_valid, bus.rsp_data, bus.rsp_err);
      end
      bus.req = '0;
      tick(1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_wrap_skip();
      test_timeout_lo();
      test_timeout_hi();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
Round-robin arbiter and sequencer that shares one calc datapath (8-bit operand, 2-bit op, s/done handshake, 8-bit out, ovf) between NREQ requesters. It grants one requester, drives the operand and op onto calc, and pulses s. It then tracks calc's done handshake, captures out/ovf and returns them to the granted requester with a one-cycle response pulse. It sits between the client blocks and the single calc instance; calc keeps its own reset.

Parameters:
NREQ, 4, number of requesters (2..8)
TMO, 15, max cycles in each wait state before an error response (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level
req_in  in  8*NREQ  operand; requester i uses bits [8i+7:8i]
req_op  in  2*NREQ  op code; requester i uses bits [2i+1:2i]
gnt  out  NREQ  one-hot grant, held from ISSUE through RESP
rsp_valid  out  NREQ  one-cycle pulse to the granted requester
rsp_data  out  8  captured calc out, valid while rsp_valid nonzero
rsp_ovf  out  1  captured calc ovf
rsp_err  out  1  timeout flag, valid while rsp_valid nonzero
calc_s  out  1  start pulse to calc
calc_in  out  8  operand to calc, held stable from ISSUE to end of WAIT_HI
calc_op  out  2  op to calc, held like calc_in
calc_done  in  1  calc idle/finished indicator
calc_out  in  8  calc result
calc_ovf  in  1  calc overflow

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=0, gnt=0, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_err=0, calc_s=0, calc_in=0, calc_op=0, timer=0.
- All outputs are registered or a decode of state only. No combinational path from inputs to outputs.
- Round-robin selection: search req starting at index ptr and wrapping at NREQ-1 to 0. The first set bit wins.
- Pointer update: ptr becomes winner+1 (mod NREQ) on leaving RESP. ptr is unchanged on an error response.
- IDLE: if any req bit is set, latch the winner index, gnt, calc_in=req_in[winner] and calc_op=req_op[winner]; go to ISSUE. Otherwise stay. Requests are sampled only in IDLE.
- ISSUE (1 cycle): calc_s=1; timer cleared; go to WAIT_LO.
- WAIT_LO: wait for calc_done==0, which means calc has accepted the start.
  - calc_done==0: go to WAIT_HI, timer cleared.
  - Otherwise timer+1; if timer reaches TMO, go to RESP with err=1.
- WAIT_HI: wait for calc_done==1.
  - calc_done==1: capture rsp_data=calc_out and rsp_ovf=calc_ovf in the same edge; go to RESP with err=0.
  - Timeout as in WAIT_LO: go to RESP with err=1, rsp_data=0, rsp_ovf=0.
- RESP (1 cycle): rsp_valid[winner]=1 and rsp_err=err. Next state IDLE; gnt clears.
  - rsp_data, rsp_ovf and rsp_err hold their values until the next capture.
- Minimum latency: req high in IDLE at cycle 0, calc_s at cycle 1, rsp_valid at cycle 3 + calc busy cycles.
- Throughput: back-to-back requests need at least one IDLE cycle between RESP and the next ISSUE.
- Requester contract:
  - Hold req, operand and op stable until rsp_valid.
  - Drop req in the cycle after rsp_valid; otherwise it is re-arbitrated as a new request.
  - Dropping req while granted is ignored; the transaction completes and rsp_valid is still pulsed.
- calc_done==0 while in IDLE is tolerated, because the arbiter waits in WAIT_LO/WAIT_HI anyway.
- Reset mid-transaction aborts with no response pulse. The arbiter does not reset calc.
- Timer width is ceil(log2(TMO+1)); the timer saturates and never wraps.

Decomposition:
- Shared package: state encodings (IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP; 3 bits), calc op code constants (ZERO=00, ADD=01, SHR=10) and the calc handshake widths.
- One sub-module, rr_pick: combinational round-robin priority picker (req, ptr -> one-hot winner, index, any).
- The FSM, timer and capture registers stay in calc_arbiter, built on vDFFE/vDFF style registers. The async reset is applied on the state, ptr and output registers.

Test Plan:
- Single request (calc model: done drops 1 cycle after s, rises 2 cycles later):
  - Stimulus: req=0001, req_in[0]=8'h05, op=01.
  - Required: gnt=0001 at cycle 1, calc_s pulse at cycle 1 with calc_in=05 and calc_op=01.
  - Required: rsp_valid=0001 with rsp_data equal to the model output and rsp_err=0.
- Fairness:
  - Stimulus: req=1111 held, each requester dropping req for one cycle after its rsp_valid.
  - Required: grants in order 0,1,2,3,0.
  - Required: no requester granted twice before all others are served once.
- Wrap and skip:
  - Stimulus: ptr=3 after serving requester 2, then req=0101.
  - Required: requester 0 granted, then requester 2.
- Timeout in WAIT_LO:
  - Stimulus: calc_done stuck at 1, TMO=15.
  - Required: rsp_valid pulse with rsp_err=1 and rsp_data=0 exactly 16 cycles after calc_s; ptr unchanged.
- Timeout in WAIT_HI:
  - Stimulus: calc_done stuck at 0 after start.
  - Required: rsp_err=1 after TMO cycles in WAIT_HI; next arbitration proceeds normally.
- Async reset:
  - Stimulus: assert reset mid-edge while in WAIT_HI.
  - Required: gnt=0, calc_s=0 and rsp_valid=0 immediately, with no response pulse.
  - Required: after deassert, req=0010 is granted at the first IDLE cycle, with ptr=0 search order.
